mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
Memory-side responder for the accumulator CPU's word-addressed memory bus (cs/we/oe, 28-bit address, 32-bit data). It replaces the bare synchronous RAM with a latency-configurable target. It adds a ready handshake, a read-valid pulse, range checking against a base address, and split read/write data with a drive-enable for an external tristate wrapper. The CPU fetch/load/store sequencer issues requests; this block services them.

Parameters:
ADDR_WIDTH, 28, bus address width (word address)
DATA_WIDTH, 32, word width
DEPTH_LOG2, 10, log2 of storage words
READ_LATENCY, 2, edges from read accept to rvalid; legal 1..4
BASE_ADDR, 'h0000000, first word address decoded by this block

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
cs  in  1  chip select; request present
we  in  1  write enable
oe  in  1  output enable; read request when we=0
addr  in  ADDR_WIDTH  word address
wdata  in  DATA_WIDTH  write data
rdata  out  DATA_WIDTH  read data; holds last completed read
rvalid  out  1  one-cycle pulse: rdata updated this cycle
ready  out  1  request accepted at next edge when cs=1
err  out  1  one-cycle pulse: out-of-range access or we&oe conflict
data_oe  out  1  drive enable for the shared data bus

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, rvalid=0, err=0, data_oe=0, rdata=0, latency counter=0. Storage is not cleared. An in-flight read is aborted with no rvalid.
- Accept condition: cs=1 and ready=1 at a rising edge. cs=1 with we=0 and oe=0 is a no-op, and err stays 0.
- Decode: in range iff addr>=BASE_ADDR and (addr-BASE_ADDR)<2**DEPTH_LOG2. Index is (addr-BASE_ADDR)[DEPTH_LOG2-1:0]. The subtraction is ADDR_WIDTH wide with no wrap; addr<BASE_ADDR is out of range.
- Write (we=1): committed at the accept edge with zero wait states. ready stays 1, so back-to-back writes run one per cycle. An out-of-range write is discarded and err=1 for the following cycle.
- we=1 and oe=1 together: treated as a write; err=1 for the following cycle.
- Read (we=0, oe=1): the address is latched at the accept edge, then IDLE->READ with counter=READ_LATENCY-1.
  - In READ: ready=0 and the counter decrements each edge.
  - At the edge where the counter reaches 0 (or at the accept edge when READ_LATENCY=1), rdata is loaded, rvalid=1 for one cycle, and the state returns to IDLE.
  - ready=1 again during the rvalid cycle, so a new request can be accepted at the next edge. Read throughput is one per READ_LATENCY cycles.
- Out-of-range read: completes with normal timing, rdata=0, and err=1 in the same cycle as rvalid.
- Read-after-write to the same index returns the new data, including a write accepted on the edge immediately before the read.
- Dropping cs or oe during READ does not cancel the read; it completes and rvalid still pulses.
- Requests arriving while ready=0 are ignored, not queued.
- data_oe: rises with rvalid. It stays 1 while cs=1, oe=1 and we=0, and falls the cycle after any of those deassert or a new request is accepted.
- rdata holds its value until the next completed read or reset.

Decomposition:
- Shared package mem_bus_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - A responder state enum (IDLE, READ).
  - An ERR_DATA constant (0) returned on out-of-range reads.
  - A bus op encoding (NOP, RD, WR) derived from cs/we/oe.
- Storage is one natural sub-module, mem_array_sp: a single-port synchronous array with one write and one registered read per cycle and no reset. The handshake FSM and latency counter stay in mem_bus_responder.

Test Plan:
- Reset then write 'h100..'h115 with the Fibonacci program words (e.g. 'h100<-'h20000113, 'h115<-'hFFFFFFFF), one per cycle -> ready=1 every cycle, err=0 throughout.
- Read 'h114 with READ_LATENCY=2 -> ready=0 for 1 cycle; rvalid pulses exactly 2 edges after accept; rdata='d10; data_oe=1 until oe drops.
- Write 'h111<-'d7 then read 'h111 on the next edge -> rdata='d7. Sweep READ_LATENCY 1 and 4: rvalid arrives 1 and 4 edges after accept respectively.
- Read addr=2**DEPTH_LOG2+BASE_ADDR -> rdata=0, rvalid=1 and err=1 in the same cycle. Write to the same address -> err pulse; a subsequent read of index 0 is unchanged.
- Assert reset one cycle after accepting a read of 'h112 -> no rvalid, ready=1 and rdata=0 immediately. Reading 'h112 after deassert returns 'd1, showing storage is preserved.
- cs=1, we=1, oe=1 with addr 'h113, wdata 'h55 -> err pulse; a later read of 'h113 returns 'h55. A second request issued while ready=0 is ignored: exactly one rvalid.

Source files
------------

// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory-bus responder: default widths, FSM states,
// the out-of-range read value and the cs/we/oe operation decode.
package mem_bus_pkg;

    localparam int DEF_ADDR_WIDTH = 28;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [DEF_DATA_WIDTH-1:0] ERR_DATA = '0;

    typedef enum logic {
        IDLE,
        READ
    } resp_state_e;

    typedef enum logic [1:0] {
        NOP,
        RD,
        WR
    } bus_op_e;

    // A write wins over a read when both strobes are up.
    function automatic bus_op_e decode_op(input logic cs, input logic we, input logic oe);
        if (!cs) begin
            return NOP;
        end
        if (we) begin
            return WR;
        end
        if (oe) begin
            return RD;
        end
        return NOP;
    endfunction

endpackage

// File: rtl/mem_bus_responder_mem_array_sp.sv
// Single-port word storage: one write or one registered read per cycle, no reset.
module mem_array_sp
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Latency-configurable memory target for the accumulator CPU bus: zero-wait
// writes, READ_LATENCY-cycle reads with rvalid, range checking and data_oe.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int                    DEPTH_LOG2   = 10,
    parameter int                    READ_LATENCY = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  ready,
    output logic                  err,
    output logic                  data_oe
);

    resp_state_e           state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  oor_q, oor_d;
    logic                  ready_q, ready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic                  data_oe_q, data_oe_d;
    logic                  zero_q, zero_d;

    bus_op_e               op;
    logic                  borrow;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_range;
    logic                  accept;
    logic                  complete;
    logic                  mem_we, mem_re;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // The borrow bit flags addr < BASE_ADDR without a wrapping compare.
    assign {borrow, offset} = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign in_range = !borrow && ((offset >> DEPTH_LOG2) == '0);
    assign op       = decode_op(cs, we, oe);
    assign accept   = ready_q && (op != NOP) && !reset;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        oor_d    = oor_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        zero_d   = zero_q;
        complete = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_idx  = idx_q;
        unique case (state_q)
            IDLE: begin
                mem_idx = offset[DEPTH_LOG2-1:0];
                if (accept && op == WR) begin
                    mem_we = in_range;
                    err_d  = !in_range || oe;
                end else if (accept && READ_LATENCY == 1) begin
                    mem_re   = 1'b1;
                    complete = 1'b1;
                    err_d    = !in_range;
                    zero_d   = !in_range;
                end else if (accept) begin
                    state_d = READ;
                    cnt_d   = 3'(READ_LATENCY - 1);
                    idx_d   = offset[DEPTH_LOG2-1:0];
                    oor_d   = !in_range;
                end
            end
            READ: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d  = IDLE;
                    mem_re   = 1'b1;
                    complete = 1'b1;
                    err_d    = oor_q;
                    zero_d   = oor_q;
                end
            end
        endcase
        rvalid_d  = complete;
        ready_d   = (state_d == IDLE);
        data_oe_d = complete || (data_oe_q && cs && oe && !we && !accept);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            oor_q     <= 1'b0;
            ready_q   <= 1'b1;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            data_oe_q <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            oor_q     <= oor_d;
            ready_q   <= ready_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            data_oe_q <= data_oe_d;
            zero_q    <= zero_d;
        end
    end

    mem_array_sp #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk  (clock),
        .we   (mem_we),
        .re   (mem_re),
        .idx  (mem_idx),
        .wdata(wdata),
        .rdata(mem_rdata)
    );

    // The array output is only masked, never reset, so storage survives reset.
    assign rdata   = zero_q ? DATA_WIDTH'(ERR_DATA) : mem_rdata;
    assign rvalid  = rvalid_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign data_oe = data_oe_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Drives three responders (latency 2, 1, 4; the last with a nonzero base) from
// shared stimulus and checks each against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_mem_bus_responder;

    localparam int NI = 3;
    localparam int AW = 28;
    localparam int DW = 32;
    localparam int DL = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cs = 1'b0, we = 1'b0, oe = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;

    logic [DW-1:0] rdata_o  [NI];
    logic          rvalid_o [NI];
    logic          ready_o  [NI];
    logic          err_o    [NI];
    logic          doe_o    [NI];

    always #5 clock = ~clock;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int            LAT  = (gi == 0) ? 2 : (gi == 1) ? 1 : 4;
        localparam logic [AW-1:0] BASE = (gi == 2) ? 28'h100 : 28'h0;
        mem_bus_responder #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL),
            .READ_LATENCY(LAT), .BASE_ADDR(BASE)
        ) u_dut (
            .clock(clock), .reset(reset), .cs(cs), .we(we), .oe(oe),
            .addr(addr), .wdata(wdata), .rdata(rdata_o[gi]),
            .rvalid(rvalid_o[gi]), .ready(ready_o[gi]), .err(err_o[gi]),
            .data_oe(doe_o[gi])
        );
    end

    function automatic int lat_of(int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 4;
    endfunction

    function automatic int base_of(int k);
        return (k == 2) ? 'h100 : 0;
    endfunction

    function automatic bit oor_of(int k, int a);
        int off;
        off = a - base_of(k);
        return (off < 0) || (off >= (1 << DL));
    endfunction

    function automatic int key_of(int k, int a);
        return k * 65536 + (a - base_of(k));
    endfunction

    // Reference model: storage per instance, and each pending read as the
    // absolute edge number at which its data must appear.
    logic [31:0] mdl_mem [int];
    bit          pend [NI];
    int          due  [NI];
    int          pkey [NI];
    bit          poor [NI];
    logic [31:0] e_rdata [NI];
    bit          e_known [NI];
    bit          e_ready [NI], e_rvalid [NI], e_err [NI], e_doe [NI];
    int          cyc = 0;

    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            pend[k]     = 1'b0;
            e_rdata[k]  = '0;
            e_known[k]  = 1'b1;
            e_ready[k]  = 1'b1;
            e_rvalid[k] = 1'b0;
            e_err[k]    = 1'b0;
            e_doe[k]    = 1'b0;
        end
    endtask

    task automatic model_edge();
        cyc++;
        for (int k = 0; k < NI; k++) begin
            bit acc, done, d_oor, n_err, n_doe;
            int d_key;
            acc   = cs && e_ready[k] && (we || oe);
            done  = 1'b0;
            d_oor = 1'b0;
            d_key = 0;
            n_err = 1'b0;
            if (pend[k] && cyc == due[k]) begin
                done    = 1'b1;
                pend[k] = 1'b0;
                d_oor   = poor[k];
                d_key   = pkey[k];
            end else if (acc && we) begin
                if (!oor_of(k, int'(addr))) mdl_mem[key_of(k, int'(addr))] = wdata;
                n_err = oor_of(k, int'(addr)) || oe;
            end else if (acc) begin
                if (lat_of(k) == 1) begin
                    done  = 1'b1;
                    d_oor = oor_of(k, int'(addr));
                    d_key = key_of(k, int'(addr));
                end else begin
                    pend[k] = 1'b1;
                    due[k]  = cyc + lat_of(k) - 1;
                    poor[k] = oor_of(k, int'(addr));
                    pkey[k] = key_of(k, int'(addr));
                end
            end
            if (done) begin
                n_err = d_oor;
                if (d_oor) begin
                    e_rdata[k] = '0;
                    e_known[k] = 1'b1;
                end else if (mdl_mem.exists(d_key)) begin
                    e_rdata[k] = mdl_mem[d_key];
                    e_known[k] = 1'b1;
                end else begin
                    e_known[k] = 1'b0;
                end
            end
            n_doe       = done || (e_doe[k] && cs && oe && !we && !acc);
            e_rvalid[k] = done;
            e_err[k]    = n_err;
            e_doe[k]    = n_doe;
            e_ready[k]  = !pend[k];
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            chk("ready", k, 32'(ready_o[k]), 32'(e_ready[k]));
            chk("rvalid", k, 32'(rvalid_o[k]), 32'(e_rvalid[k]));
            chk("err", k, 32'(err_o[k]), 32'(e_err[k]));
            chk("data_oe", k, 32'(doe_o[k]), 32'(e_doe[k]));
            if (e_known[k]) chk("rdata", k, rdata_o[k], e_rdata[k]);
        end
    endtask

    task automatic step(input logic c, input logic w, input logic o, input int a, input logic [31:0] d);
        cs    = c;
        we    = w;
        oe    = o;
        addr  = AW'(a);
        wdata = d;
        if (c) $display("txn cyc=%0d cs=%b we=%b oe=%b addr=%h wdata=%h", cyc + 1, c, w, o, addr, d);
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, '0);
    endtask

    // Async reset asserted mid-cycle; outputs must clear before any edge.
    task automatic pulse_reset();
        cs = 1'b0;
        we = 1'b0;
        oe = 1'b0;
        #1 reset = 1'b1;
        #1;
        $display("txn cyc=%0d reset", cyc);
        model_reset();
        check_all();
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] prog [22];
        int          alist [11];
        int          first [NI];
        int          rv_cnt;

        prog = '{32'h20000113, 32'h00000093, 32'h00100113, 32'h00000193,
                 32'h00A00213, 32'h002081B3, 32'h00010093, 32'h00018113,
                 32'hFFF20213, 32'hFE0216E3, 32'h00302023, 32'h0000006F,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 32'h00000001, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF};
        alist = '{'h000, 'h050, 'h0FF, 'h100, 'h10A, 'h111, 'h114, 'h3FF, 'h400, 'h4FF, 'h500};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        check_all();
        reset = 1'b0;
        #1;

        // Program load, one write per cycle
        for (int i = 0; i < 22; i++) step(1'b1, 1'b1, 1'b0, 'h100 + i, prog[i]);
        step(1'b1, 1'b1, 1'b0, 'h000, 32'hA5A50000);
        step(1'b1, 1'b1, 1'b0, 'h050, 32'h00000050);
        idle(1);

        // Read 'h114 and measure edges from accept to rvalid per instance
        for (int k = 0; k < NI; k++) first[k] = 0;
        step(1'b1, 1'b0, 1'b1, 'h114, '0);
        for (int k = 0; k < NI; k++) if (rvalid_o[k] && first[k] == 0) first[k] = 1;
        for (int n = 2; n <= 6; n++) begin
            step(1'b0, 1'b0, 1'b1, 'h114, '0);
            for (int k = 0; k < NI; k++) if (rvalid_o[k] && first[k] == 0) first[k] = n;
        end
        for (int k = 0; k < NI; k++) chk("latency", k, 32'(first[k]), 32'(lat_of(k)));
        idle(1);

        // Read immediately after a write to the same word
        step(1'b1, 1'b1, 1'b0, 'h111, 32'd7);
        step(1'b1, 1'b0, 1'b1, 'h111, '0);
        idle(5);

        // Range boundary: read, write, then confirm index 0 untouched
        step(1'b1, 1'b0, 1'b1, 'h400, '0);
        idle(5);
        step(1'b1, 1'b1, 1'b0, 'h400, 32'hBAD0BAD0);
        idle(1);
        step(1'b1, 1'b0, 1'b1, 'h000, '0);
        idle(5);
        step(1'b1, 1'b0, 1'b1, 'h0FF, '0);
        idle(5);

        // Reset aborts an in-flight read; storage survives
        step(1'b1, 1'b0, 1'b1, 'h112, '0);
        pulse_reset();
        idle(1);
        step(1'b1, 1'b0, 1'b1, 'h112, '0);
        idle(5);

        // we&oe conflict, then a request while busy is dropped
        step(1'b1, 1'b1, 1'b1, 'h113, 32'h55);
        idle(1);
        rv_cnt = 0;
        step(1'b1, 1'b0, 1'b1, 'h113, '0);
        rv_cnt += int'(rvalid_o[0]);
        step(1'b1, 1'b0, 1'b1, 'h112, '0);
        rv_cnt += int'(rvalid_o[0]);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 0, '0);
            rv_cnt += int'(rvalid_o[0]);
        end
        chk("rvalid_count", 0, 32'(rv_cnt), 32'd1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            int          a;
            int unsigned r;
            a = alist[$urandom_range(0, 10)];
            r = $urandom_range(0, 7);
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else if (r < 2) step(1'b0, 1'(r), 1'($urandom_range(0, 1)), a, $urandom);
            else if (r < 4) step(1'b1, 1'b1, 1'b0, a, $urandom);
            else if (r == 4) step(1'b1, 1'b1, 1'b1, a, $urandom);
            else if (r == 5) step(1'b1, 1'b0, 1'b0, a, $urandom);
            else step(1'b1, 1'b0, 1'b1, a, '0);
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
